stream_demux: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 16 +
 rtl/stream_demux_lane.sv | 59 +++++
 rtl/stream_demux.sv | 78 +++++++
 tb/tb_stream_demux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer and its lanes.
package demux_pkg;

  // Largest lane count the demux is built and checked for.
  localparam int DEMUX_MAX_OUTPUTS = 16;

  // Width of the saturating drop counter.
  localparam int DROP_COUNT_WIDTH = 8;

  // Occupancy of a single lane's one-entry output slot.
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

endpackage : demux_pkg

// File: rtl/stream_demux_lane.sv
// One output lane of the demux: a one-entry registered slot with
// valid/ready handshake toward its consumer.
module demux_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_accept
);

  lane_state_e      state_r;
  logic [WIDTH-1:0] data_r;

  // Slot state machine: load fills (or refills on a same-cycle drain), drain empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LANE_EMPTY;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        LANE_EMPTY: begin
          if (load) begin
            state_r <= LANE_FULL;
            data_r  <= load_data;
          end else begin
            state_r <= LANE_EMPTY;
          end
        end
        LANE_FULL: begin
          // The top only loads a full lane when its consumer is draining,
          // so a load here always replaces a beat that has just left.
          if (load) begin
            state_r <= LANE_FULL;
            data_r  <= load_data;
          end else if (out_ready) begin
            state_r <= LANE_EMPTY;
          end else begin
            state_r <= LANE_FULL;
          end
        end
        default: begin
          state_r <= LANE_EMPTY;
        end
      endcase
    end
  end

  assign out_valid  = (state_r == LANE_FULL);
  assign out_data   = data_r;
  assign can_accept = (state_r == LANE_EMPTY) | out_ready;

endmodule : demux_lane

// File: rtl/stream_demux.sv
// Distributes one valid/ready stream over NUM_OUTPUTS registered lanes,
// chosen per beat by in_select. Beats with an out-of-range select are
// consumed and counted in a saturating drop counter. Legal NUM_OUTPUTS: 2..16.
module stream_demux
  import demux_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int NUM_OUTPUTS = 4,
  localparam int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_WIDTH-1:0]        in_select,
  output logic [NUM_OUTPUTS-1:0]      out_valid,
  input  logic [NUM_OUTPUTS-1:0]      out_ready,
  output logic [WIDTH-1:0]            out_data [NUM_OUTPUTS-1:0],
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam logic [SEL_WIDTH:0]        LANE_LIMIT = (SEL_WIDTH + 1)'(NUM_OUTPUTS);
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = {DROP_COUNT_WIDTH{1'b1}};

  logic                        sel_legal_s;
  logic                        in_ready_s;
  logic                        accept_s;
  logic [NUM_OUTPUTS-1:0]      can_accept_s;
  logic [NUM_OUTPUTS-1:0]      load_s;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_r;

  assign sel_legal_s = ({1'b0, in_select} < LANE_LIMIT);

  // in_ready follows the selected lane; illegal selects are always swallowed.
  always_comb begin
    in_ready_s = 1'b1;
    if (sel_legal_s) begin
      in_ready_s = can_accept_s[in_select];
    end else begin
      in_ready_s = 1'b1;
    end
  end

  assign accept_s = in_valid & in_ready_s;
  assign in_ready = in_ready_s;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
    assign load_s[i] = accept_s & sel_legal_s & (in_select == SEL_WIDTH'(i));

    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i]),
      .can_accept(can_accept_s[i])
    );
  end

  // Count accepted beats whose select names no lane, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= {DROP_COUNT_WIDTH{1'b0}};
    end else if (accept_s && !sel_legal_s && (drop_count_r != DROP_MAX)) begin
      drop_count_r <= drop_count_r + {{(DROP_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign drop_count = drop_count_r;

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a 4-lane instance driven by
// directed and random traffic against a slot-occupancy model, plus a
// 3-lane instance exercising out-of-range selects and drop saturation.
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 4-lane instance
  logic       in_valid4, in_ready4;
  logic [7:0] in_data4;
  logic [1:0] in_select4;
  logic [3:0] out_valid4, out_ready4;
  logic [7:0] out_data4 [3:0];
  logic [7:0] drop4;

  // 3-lane instance
  logic       in_valid3, in_ready3;
  logic [7:0] in_data3;
  logic [1:0] in_select3;
  logic [2:0] out_valid3, out_ready3;
  logic [7:0] out_data3 [2:0];
  logic [7:0] drop3;

  stream_demux #(.WIDTH(8), .NUM_OUTPUTS(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_select(in_select4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .drop_count(drop4)
  );

  stream_demux #(.WIDTH(8), .NUM_OUTPUTS(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_select(in_select3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .drop_count(drop3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the 4-lane instance: which lanes hold a beat, and what
  // each lane last received (cleared to zero by reset).
  bit       m_known = 1'b0;
  bit       m_full [4];
  bit [7:0] m_data [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the 4-lane instance: drive, compare at negedge, advance model.
  task automatic cycle4(input logic v, input logic [1:0] sel, input logic [7:0] d,
                        input logic [3:0] rdy, input logic rst);
    bit       exp_ready;
    bit [3:0] exp_valid;
    reset      = rst;
    in_valid4  = v;
    in_select4 = sel;
    in_data4   = d;
    out_ready4 = rdy;
    @(negedge clk);
    exp_ready = !m_full[sel] || rdy[sel];
    if (m_known) begin
      for (int i = 0; i < 4; i++) exp_valid[i] = m_full[i];
      chk("out_valid", {28'd0, out_valid4}, {28'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready4}, {31'd0, exp_ready});
      chk("drop_count4", {24'd0, drop4}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_data[%0d]", i), {24'd0, out_data4[i]}, {24'd0, m_data[i]});
      end
    end
    if (rst) begin
      m_known = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
      end
      if (v && exp_ready) begin
        m_full[sel] = 1'b1;
        m_data[sel] = d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [7:0] d;
    int       exp_drop;

    reset      = 1'b1;
    in_valid4  = 1'b0; in_select4 = 2'd0; in_data4 = 8'h00; out_ready4 = 4'hf;
    in_valid3  = 1'b0; in_select3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'h7;

    // Reset, then idle with all consumers ready.
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b1);
    for (int i = 0; i < 3; i++) cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);

    // One beat per lane on consecutive cycles; each pulses for one cycle.
    cycle4(1'b1, 2'd0, 8'h3a, 4'hf, 1'b0);
    cycle4(1'b1, 2'd1, 8'h6b, 4'hf, 1'b0);
    cycle4(1'b1, 2'd2, 8'hf3, 4'hf, 1'b0);
    cycle4(1'b1, 2'd3, 8'h45, 4'hf, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);

    // Lane 2 stalled: second beat waits, then drains and reloads on one edge.
    cycle4(1'b1, 2'd2, 8'hf3, 4'hb, 1'b0);
    cycle4(1'b1, 2'd2, 8'h11, 4'hb, 1'b0);
    cycle4(1'b1, 2'd2, 8'h11, 4'hb, 1'b0);
    cycle4(1'b1, 2'd2, 8'h11, 4'hf, 1'b0);
    // Lane 2 now FULL with 8'h11 and stalled; lane 0 still accepts.
    cycle4(1'b1, 2'd0, 8'h55, 4'hb, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hb, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);

    // Reset while lane 1 holds a stalled beat; it must never appear.
    cycle4(1'b1, 2'd1, 8'h6b, 4'hd, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hd, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hd, 1'b1);
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);
    cycle4(1'b0, 2'd0, 8'h00, 4'hf, 1'b0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      cycle4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
             4'($urandom), ($urandom_range(0, 63) == 0));
    end

    // 3-lane instance: select 3 names no lane, so every beat is dropped.
    in_valid4 = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_drop = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid3  = 1'b1;
      in_select3 = 2'd3;
      in_data3   = 8'($urandom);
      out_ready3 = 3'($urandom);
      @(negedge clk);
      chk("drop_ready", {31'd0, in_ready3}, 32'd1);
      chk("drop_valid", {29'd0, out_valid3}, 32'd0);
      chk("drop_count", {24'd0, drop3}, exp_drop);
      if (exp_drop < 255) exp_drop++;
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("drop_sat", {24'd0, drop3}, 32'd255);
    @(posedge clk); #1;

    // A legal beat still reaches its lane after saturation.
    d          = 8'hc7;
    in_valid3  = 1'b1;
    in_select3 = 2'd2;
    in_data3   = d;
    out_ready3 = 3'b000;
    @(negedge clk);
    chk("legal3_ready", {31'd0, in_ready3}, 32'd1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("legal3_valid", {29'd0, out_valid3}, 32'd4);
    chk("legal3_data", {24'd0, out_data3[2]}, {24'd0, d});
    chk("legal3_drop", {24'd0, drop3}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stream_demux
